// File: rtl/img_tx_scheduler_pkg.sv
// Shared types for the image readback scheduler: FSM state encoding and header byte format.
// Purely declarative; no timing or flow control of its own.
package img_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        FETCH  = 3'd2,
        SEND   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    function automatic logic [7:0] hdr_byte(input logic [3:0] src_idx);
        return {HDR_MAGIC, src_idx};
    endfunction

endpackage

// File: rtl/img_tx_scheduler_if.sv
// Bundle of the scheduler's request, BRAM read and byte-transmit signals.
// master = scheduler side, slave = BRAMs / requesters / UART wrapper side.
interface img_tx_scheduler_if #(
    parameter int NUM_SRC    = 4,
    parameter int ADDR_WIDTH = 15
);
    logic [NUM_SRC-1:0]    req_in;
    logic [8*NUM_SRC-1:0]  rd_data_in;
    logic                  tx_ready_in;
    logic [NUM_SRC-1:0]    grant_out;
    logic [ADDR_WIDTH-1:0] rd_addr_out;
    logic [7:0]            tx_data_out;
    logic                  tx_valid_out;
    logic [NUM_SRC-1:0]    done_out;
    logic                  busy_out;

    modport master (
        input  req_in, rd_data_in, tx_ready_in,
        output grant_out, rd_addr_out, tx_data_out, tx_valid_out, done_out, busy_out
    );

    modport slave (
        output req_in, rd_data_in, tx_ready_in,
        input  grant_out, rd_addr_out, tx_data_out, tx_valid_out, done_out, busy_out
    );
endinterface

// File: rtl/img_tx_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request searching upward (with wrap) from last_grant+1.
// Purely combinational, zero latency; no backpressure.
module rr_arbiter #(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return IDX_W'(s);
    endfunction

    // Offsets 1..NUM_SRC visit every source once, last_grant itself last.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            if (!any_req && req[wrap_idx(last_grant, off)]) begin
                any_req                        = 1'b1;
                grant[wrap_idx(last_grant, off)] = 1'b1;
                idx                            = wrap_idx(last_grant, off);
            end
        end
    end

endmodule

// File: rtl/img_tx_scheduler.sv
// Shares one byte link among image buffers: header byte, then every pixel read from the granted BRAM.
// Per pixel BRAM_LATENCY+2 cycles with ready high; tx_valid holds with stable data until tx_ready.
module img_tx_scheduler
    import img_tx_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int ADDR_WIDTH   = 15,
    parameter int IMG_PIXELS   = 16384,
    parameter int BRAM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_in,
    img_tx_scheduler_if.master bus
);

    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int WAIT_W = $clog2(BRAM_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(IMG_PIXELS - 1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(BRAM_LATENCY);

    state_t                state_q, state_d;
    logic [NUM_SRC-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [7:0]            pix_q, pix_d;

    logic [NUM_SRC-1:0]    arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic [7:0]            sel_dat;
    logic                  tx_vld;
    logic [7:0]            tx_dat;
    logic [NUM_SRC-1:0]    done_o;
    logic                  tx_hs;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req        (bus.req_in),
        .last_grant (last_q),
        .grant      (arb_grant),
        .idx        (arb_idx),
        .any_req    (arb_any)
    );

    // grant_q is one-hot, so an OR of masked lanes is the read-data mux.
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) sel_dat = sel_dat | bus.rd_data_in[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_SRC - 1);
            addr_q  <= '0;
            wait_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            pix_q   <= pix_d;
        end
    end

    assign tx_hs = tx_vld & bus.tx_ready_in;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        pix_d   = pix_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (tx_hs) begin
                    addr_d  = '0;
                    wait_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Address has been stable for BRAM_LATENCY cycles on the last count.
                if (wait_q == WAIT_LAST) begin
                    pix_d   = sel_dat;
                    state_d = SEND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            SEND: begin
                if (tx_hs) begin
                    wait_d = '0;
                    if (addr_q == ADDR_LAST) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                last_d  = gidx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_vld = 1'b0;
        tx_dat = '0;
        done_o = '0;
        case (state_q)
            HEADER: begin
                tx_vld = 1'b1;
                tx_dat = hdr_byte(4'(gidx_q));
            end
            SEND: begin
                tx_vld = 1'b1;
                tx_dat = pix_q;
            end
            DONE:    done_o = grant_q;
            default: ;
        endcase
    end

    assign bus.tx_valid_out = tx_vld;
    assign bus.tx_data_out  = tx_dat;
    assign bus.done_out     = done_o;
    assign bus.busy_out     = (state_q != IDLE);
    assign bus.grant_out    = (state_q != IDLE) ? grant_q : '0;
    assign bus.rd_addr_out  = addr_q;

endmodule

// File: tb/tb_img_tx_scheduler.sv
// Directed bench for img_tx_scheduler: byte scoreboard, handshake stability, done pulses, latency build.
module tb_img_tx_scheduler;

    localparam int NS   = 4;
    localparam int AW   = 15;
    localparam int NPIX = 4;

    logic clk = 1'b0;
    logic rst_in;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    img_tx_scheduler_if #(.NUM_SRC(NS), .ADDR_WIDTH(AW)) bus ();
    img_tx_scheduler_if #(.NUM_SRC(NS), .ADDR_WIDTH(AW)) bus_l1 ();

    img_tx_scheduler #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .IMG_PIXELS(NPIX), .BRAM_LATENCY(2)) dut (
        .clk(clk), .rst_in(rst_in), .bus(bus)
    );
    img_tx_scheduler #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .IMG_PIXELS(NPIX), .BRAM_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_in(rst_in), .bus(bus_l1)
    );

    function automatic logic [7:0] pix_byte(input int src, input logic [AW-1:0] a);
        return {2'(src), a[5:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // BRAM models with true pipeline latency (2 and 1 cycles).
    logic [AW-1:0] a2_p0, a2_p1, a1_p0;
    always @(posedge clk) begin
        a2_p0 <= bus.rd_addr_out;
        a2_p1 <= a2_p0;
        a1_p0 <= bus_l1.rd_addr_out;
    end
    always_comb begin
        bus.rd_data_in = '0;
        for (int i = 0; i < NS; i++) bus.rd_data_in[8*i +: 8] = pix_byte(i, a2_p1);
    end
    always_comb begin
        bus_l1.rd_data_in = '0;
        for (int i = 0; i < NS; i++) bus_l1.rd_data_in[8*i +: 8] = pix_byte(i, a1_p0);
    end

    int       exp_q[$];
    int       done_cnt[NS];
    logic     prev_stall;
    logic [7:0] prev_dat;
    logic [NS-1:0] prev_done;

    initial begin
        for (int i = 0; i < NS; i++) done_cnt[i] = 0;
        prev_stall = 1'b0;
        prev_done  = '0;
        prev_dat   = '0;
    end

    task automatic push_image(input int src);
        exp_q.push_back(int'({4'hA, 4'(src)}));
        for (int p = 0; p < NPIX; p++) exp_q.push_back(int'(pix_byte(src, AW'(p))));
    endtask

    // Scoreboard and protocol monitor for the main DUT.
    always @(negedge clk) begin
        int e;
        if (!rst_in) begin
            prev_stall = 1'b0;
            prev_done  = '0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.tx_valid_out, 1);
                check("hold_data", bus.tx_data_out, prev_dat);
            end
            if (bus.tx_valid_out && bus.tx_ready_in) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check("tx_byte", bus.tx_data_out, e);
            end
            if (prev_done != '0) check("done_width", bus.done_out, 0);
            for (int i = 0; i < NS; i++) if (bus.done_out[i]) done_cnt[i]++;
            prev_stall = bus.tx_valid_out && !bus.tx_ready_in;
            prev_dat   = bus.tx_data_out;
            prev_done  = bus.done_out;
        end
    end

    int l1_cyc[$];
    int l1_dat[$];
    always @(negedge clk) begin
        if (rst_in && bus_l1.tx_valid_out && bus_l1.tx_ready_in) begin
            l1_cyc.push_back(cyc);
            l1_dat.push_back(int'(bus_l1.tx_data_out));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!bus.busy_out && n < 20) begin
            tick();
            n++;
        end
        check(tag, bus.busy_out, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, bus.grant_out, 0);
        check({tag, "_addr"}, bus.rd_addr_out, 0);
        check({tag, "_data"}, bus.tx_data_out, 0);
        check({tag, "_valid"}, bus.tx_valid_out, 0);
        check({tag, "_done"}, bus.done_out, 0);
        check({tag, "_busy"}, bus.busy_out, 0);
    endtask

    initial begin
        int pulses, seen, n, d0, d3;
        int e_l1[5];

        rst_in = 1'b0;
        bus.req_in = '0;
        bus.tx_ready_in = 1'b1;
        bus_l1.req_in = '0;
        bus_l1.tx_ready_in = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_in = 1'b1;

        // Single request, ready tied high: exact timing from grant.
        push_image(2);
        bus.req_in = 4'b0100;
        wait_busy("single_grant_wait");
        check("single_grant", bus.grant_out, 4'b0100);
        check("single_hdr_valid", bus.tx_valid_out, 1);
        check("single_hdr", bus.tx_data_out, 8'hA2);
        bus.req_in = '0;
        repeat (17) tick();
        check("single_done", bus.done_out, 4'b0100);
        check("single_busy_in_done", bus.busy_out, 1);
        tick();
        check("single_idle_busy", bus.busy_out, 0);
        check("single_idle_grant", bus.grant_out, 0);
        check("single_idle_valid", bus.tx_valid_out, 0);
        check("single_sb_empty", exp_q.size(), 0);
        check("single_done_cnt", done_cnt[2], 1);

        // Round-robin from reset with all requests held.
        rst_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        d0 = done_cnt[0];
        push_image(0); push_image(1); push_image(2); push_image(3); push_image(0);
        bus.req_in = 4'b1111;
        pulses = 0;
        n = 0;
        while (pulses < 5 && n < 300) begin
            tick();
            n++;
            if (bus.done_out != '0) pulses++;
        end
        bus.req_in = '0;
        check("rr_pulses", pulses, 5);
        repeat (3) tick();
        check("rr_sb_empty", exp_q.size(), 0);
        check("rr_done0_cnt", done_cnt[0] - d0, 2);
        check("rr_idle", bus.busy_out, 0);

        // Backpressure: random ready, same byte stream as single request.
        push_image(2);
        bus.req_in = 4'b0100;
        seen = 0;
        n = 0;
        while (!seen && n < 400) begin
            tick();
            n++;
            bus.tx_ready_in = 1'($urandom_range(0, 1));
            if (bus.busy_out) bus.req_in = '0;
            if (bus.done_out[2]) seen = 1;
        end
        bus.tx_ready_in = 1'b1;
        check("bp_done_seen", seen, 1);
        tick();
        check("bp_sb_empty", exp_q.size(), 0);

        // Request dropped right after the header: image still completes.
        d0 = done_cnt[1];
        push_image(1);
        bus.req_in = 4'b0010;
        n = 0;
        while (!(bus.tx_valid_out && bus.tx_data_out == 8'hA1) && n < 20) begin
            tick();
            n++;
        end
        check("drop_hdr_seen", bus.tx_data_out, 8'hA1);
        tick();
        bus.req_in = '0;
        seen = 0;
        n = 0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (bus.done_out[1]) seen = 1;
        end
        check("drop_done_seen", seen, 1);
        tick();
        check("drop_sb_empty", exp_q.size(), 0);
        check("drop_done_cnt", done_cnt[1] - d0, 1);

        // Reset while source 3 fetches pixel 2.
        d3 = done_cnt[3];
        exp_q.push_back(int'(8'hA3));
        exp_q.push_back(int'(pix_byte(3, AW'(0))));
        exp_q.push_back(int'(pix_byte(3, AW'(1))));
        bus.req_in = 4'b1000;
        n = 0;
        while (!(bus.tx_valid_out && bus.tx_data_out == pix_byte(3, AW'(1))) && n < 50) begin
            tick();
            n++;
        end
        check("rst_mid_px1_seen", bus.tx_data_out, pix_byte(3, AW'(1)));
        tick();
        check("rst_mid_addr2", bus.rd_addr_out, 2);
        rst_in = 1'b0;
        tick();
        check_all_zero("rst_mid");
        check("rst_mid_sb_empty", exp_q.size(), 0);
        rst_in = 1'b1;
        push_image(0);
        bus.req_in = 4'b1111;
        wait_busy("rst_regrant_wait");
        check("rst_regrant", bus.grant_out, 4'b0001);
        check("rst_regrant_hdr", bus.tx_data_out, 8'hA0);
        bus.req_in = '0;
        seen = 0;
        n = 0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (bus.done_out[0]) seen = 1;
        end
        check("rst_src0_done", seen, 1);
        tick();
        check("rst_no_done3", done_cnt[3] - d3, 0);
        check("rst_sb_empty", exp_q.size(), 0);

        // BRAM_LATENCY=1 build: three cycles per pixel, data matches address.
        bus_l1.req_in = 4'b0001;
        seen = 0;
        n = 0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (bus_l1.busy_out) bus_l1.req_in = '0;
            if (bus_l1.done_out[0]) seen = 1;
        end
        check("lat1_done_seen", seen, 1);
        check("lat1_bytes", l1_dat.size(), 5);
        e_l1[0] = int'(8'hA0);
        for (int p = 0; p < NPIX; p++) e_l1[p+1] = int'(pix_byte(0, AW'(p)));
        for (int i = 0; i < 5; i++) begin
            check("lat1_data", (i < l1_dat.size()) ? l1_dat[i] : -1, e_l1[i]);
            if (i > 0) check("lat1_period", (i < l1_cyc.size()) ? l1_cyc[i] - l1_cyc[i-1] : -1, 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/img_tx_scheduler.md
# img_tx_scheduler

Round-robin scheduler that shares the single UART byte link between several image buffers (pyramid levels, DoG images) that are ready for readback. For each granted source it sends one header byte. It then walks that source's BRAM from address 0 to IMG_PIXELS-1, absorbing the read latency, and hands each pixel to the byte transmitter over a valid/ready handshake. It sits between the per-level image BRAM read ports and the UART transmit wrapper in the top level.

## Interface
- NUM_SRC, 4, number of requesting image buffers (2..16)
- ADDR_WIDTH, 15, BRAM address width
- IMG_PIXELS, 16384, pixels per image; must be ≤ 2^ADDR_WIDTH
- BRAM_LATENCY, 2, BRAM read latency in cycles (≥1)
- clk  in  1  system clock; single clock domain
- rst_in  in  1  reset, synchronous, active-low
- req_in  in  NUM_SRC  per-source "image ready", level
- rd_data_in  in  8*NUM_SRC  BRAM read data; source i occupies bits [8i+7:8i]
- tx_ready_in  in  1  byte transmitter can accept
- grant_out  out  NUM_SRC  one-hot current owner; 0 when idle
- rd_addr_out  out  ADDR_WIDTH  shared BRAM read address
- tx_data_out  out  8  byte to transmit
- tx_valid_out  out  1  tx_data_out valid
- done_out  out  NUM_SRC  one-cycle pulse when that source's image is fully sent
- busy_out  out  1  high in every state except IDLE

## Operation
- States: IDLE, HEADER, FETCH, SEND, DONE.
- IDLE:
  - If req_in is nonzero, pick the first asserted source searching upward (with wrap) from last_grant+1.
  - Latch the pick as grant and go to HEADER.
- HEADER:
  - tx_data_out = {4'hA, grant index[3:0]} and tx_valid_out=1.
  - On valid&ready: pix_addr←0, go to FETCH.
- FETCH:
  - rd_addr_out=pix_addr.
  - Wait counter runs 0..BRAM_LATENCY.
  - On its final cycle, register rd_data_in[grant] into the pixel register, then go to SEND.
- SEND:
  - tx_data_out=pixel register and tx_valid_out=1.
  - On valid&ready: if pix_addr==IMG_PIXELS-1 go to DONE; else pix_addr+1 and go to FETCH.
- DONE: done_out[grant]=1 for this cycle, last_grant←grant, go to IDLE.
- Handshake rules:
  - tx_valid_out, once high, stays high with tx_data_out stable until ready is sampled high.
  - tx_valid_out is never high in IDLE, FETCH or DONE.
- Deassertion of req_in during a transfer is ignored; the image always completes. A source must drop req_in after its done_out pulse, otherwise it is re-eligible in the next arbitration.
- rd_addr_out holds its value outside FETCH. No address wrap: the terminal compare is against IMG_PIXELS-1.
- Reset values (rst_in low at an edge, including mid-transfer):
  - State IDLE; grant_out, rd_addr_out, tx_data_out, tx_valid_out, done_out, busy_out all 0.
  - last_grant=NUM_SRC-1, so source 0 has first priority.
  - A transfer in progress is abandoned; no done_out is issued for it.

## Timing
- req_in sampled high at edge k in IDLE: grant_out, busy_out and tx_valid_out (header) are high from cycle k+1.
- FETCH entered at cycle t: rd_addr_out is valid in t; rd_data_in is sampled at the edge ending cycle t+BRAM_LATENCY; SEND starts at t+BRAM_LATENCY+1.
- With tx_ready_in tied high, the cost per pixel is BRAM_LATENCY+2 cycles.
- A full image costs 1 (header) + IMG_PIXELS·(BRAM_LATENCY+2) + 1 (DONE) cycles after grant.
- Back-to-back: IDLE takes one cycle between DONE and the next grant.

## Structure
- Shared package img_tx_pkg holds:
  - the state enum (IDLE=0, HEADER=1, FETCH=2, SEND=3, DONE=4);
  - HDR_MAGIC=4'hA.
- Sub-module rr_arbiter(NUM_SRC) handles selection:
  - Inputs: req, last_grant.
  - Outputs: one-hot grant, index and any_req.
  - It is purely combinational and is reused by later readback arbiters.

## Test plan
All scenarios use NUM_SRC=4, IMG_PIXELS=4, BRAM_LATENCY=2, and BRAM models returning data = {src[1:0], addr[5:0]}.
- Single request:
  - Stimulus: req_in=4'b0100, tx_ready_in=1.
  - Response: bytes A2,80,81,82,83; done_out[2] pulses once; 1+4·4+1 cycles after grant, busy_out=0.
- Round-robin:
  - Stimulus: all four requests held continuously after reset.
  - Response: headers A0,A1,A2,A3,A0 in order; each done_out pulse is one cycle wide.
- Backpressure:
  - Stimulus: tx_ready_in toggles pseudo-randomly.
  - Response: tx_data_out is never changed while valid&!ready; the byte sequence is identical to the single-request case.
- Request drop:
  - Stimulus: req_in[1] deasserted after its header.
  - Response: all 4 pixels are still sent, then done_out[1] pulses.
- Reset mid-image:
  - Stimulus: rst_in low during source 3's pixel 2.
  - Response: all outputs are 0 next cycle; no done_out pulse; with all requests set afterwards, source 0 is granted first.
- Latency:
  - Stimulus: BRAM_LATENCY=1 build.
  - Response: per-pixel period is 3 cycles with ready high; the data sampled matches the addressed pixel.
